// File: rtl/dcache_tag_ctrl_if.sv
// Bus bundle between the dcache pipeline, the tag controller and the tag store SRAM.
// The controller uses the slave view; the pipeline/SRAM side uses the master view.
interface dcache_tag_ctrl_if #(
    parameter int TAG_WIDTH = 20,
    parameter int NUM_WORDS = 256,
    localparam int IDX_W    = $clog2(NUM_WORDS)
);
    logic                   flush_i;
    logic                   flush_done_o;

    logic                   req_valid_i;
    logic                   req_ready_o;
    logic [IDX_W-1:0]       req_index_i;
    logic [TAG_WIDTH-1:0]   req_tag_i;
    logic                   req_we_i;

    logic                   rsp_valid_o;
    logic                   rsp_hit_o;
    logic                   rsp_dirty_o;
    logic [TAG_WIDTH-1:0]   rsp_victim_tag_o;

    logic                   refill_valid_i;
    logic                   refill_ready_o;
    logic [IDX_W-1:0]       refill_index_i;
    logic [TAG_WIDTH-1:0]   refill_tag_i;
    logic                   refill_dirty_i;

    logic                   ts_en_o;
    logic                   ts_we_o;
    logic [IDX_W-1:0]       ts_addr_o;
    logic [TAG_WIDTH+1:0]   ts_wdata_o;
    logic [TAG_WIDTH+1:0]   ts_bit_en_o;
    logic [TAG_WIDTH+1:0]   ts_rdata_i;

    modport slave (
        input  flush_i, req_valid_i, req_index_i, req_tag_i, req_we_i,
               refill_valid_i, refill_index_i, refill_tag_i, refill_dirty_i, ts_rdata_i,
        output flush_done_o, req_ready_o, rsp_valid_o, rsp_hit_o, rsp_dirty_o,
               rsp_victim_tag_o, refill_ready_o, ts_en_o, ts_we_o, ts_addr_o,
               ts_wdata_o, ts_bit_en_o
    );

    modport master (
        output flush_i, req_valid_i, req_index_i, req_tag_i, req_we_i,
               refill_valid_i, refill_index_i, refill_tag_i, refill_dirty_i, ts_rdata_i,
        input  flush_done_o, req_ready_o, rsp_valid_o, rsp_hit_o, rsp_dirty_o,
               rsp_victim_tag_o, refill_ready_o, ts_en_o, ts_we_o, ts_addr_o,
               ts_wdata_o, ts_bit_en_o
    );
endinterface

// File: rtl/dcache_tag_ctrl.sv
// Data cache tag store controller: lookup/compare, refill installs, store-hit dirty
// updates and a full invalidate sweep.
//
// state  | meaning
// IDLE   | accepts flush > refill > lookup; refill writes happen here in one cycle
// LOOKUP | read data returns; compare, optional dirty-bit write, register response
// FLUSH  | one invalidating write per cycle, index 0 .. NUM_WORDS-1
module dcache_tag_ctrl #(
    parameter int TAG_WIDTH = 20,
    parameter int NUM_WORDS = 256,
    localparam int IDX_W    = $clog2(NUM_WORDS)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    dcache_tag_ctrl_if.slave   bus
);
    localparam int EW        = TAG_WIDTH + 2;
    localparam int VALID_BIT = TAG_WIDTH + 1;
    localparam int DIRTY_BIT = TAG_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t               state_q, state_nxt;
    logic [IDX_W-1:0]     flush_cnt_q, flush_cnt_nxt;
    logic                 flush_done_q, flush_done_nxt;

    logic [IDX_W-1:0]     lat_index_q;
    logic [TAG_WIDTH-1:0] lat_tag_q;
    logic                 lat_we_q;

    logic                 rsp_valid_q;
    logic                 rsp_hit_q;
    logic                 rsp_dirty_q;
    logic [TAG_WIDTH-1:0] rsp_victim_q;

    logic                 ts_en, ts_we;
    logic [IDX_W-1:0]     ts_addr;
    logic [EW-1:0]        ts_wdata, ts_bit_en;
    logic                 accept_req, lookup_done;

    logic                 rd_valid, rd_dirty, hit;
    logic [TAG_WIDTH-1:0] rd_tag;

    assign rd_valid = bus.ts_rdata_i[VALID_BIT];
    assign rd_dirty = bus.ts_rdata_i[DIRTY_BIT];
    assign rd_tag   = bus.ts_rdata_i[TAG_WIDTH-1:0];
    assign hit      = rd_valid && (rd_tag == lat_tag_q);

    always_comb begin
        state_nxt      = state_q;
        flush_cnt_nxt  = flush_cnt_q;
        flush_done_nxt = 1'b0;
        accept_req     = 1'b0;
        lookup_done    = 1'b0;
        ts_en          = 1'b0;
        ts_we          = 1'b0;
        ts_addr        = '0;
        ts_wdata       = '0;
        ts_bit_en      = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.flush_i) begin
                    state_nxt = ST_FLUSH;
                end else if (bus.refill_valid_i) begin
                    ts_en     = 1'b1;
                    ts_we     = 1'b1;
                    ts_addr   = bus.refill_index_i;
                    ts_wdata  = {1'b1, bus.refill_dirty_i, bus.refill_tag_i};
                    ts_bit_en = '1;
                end else if (bus.req_valid_i) begin
                    ts_en      = 1'b1;
                    ts_addr    = bus.req_index_i;
                    accept_req = 1'b1;
                    state_nxt  = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                lookup_done = 1'b1;
                state_nxt   = ST_IDLE;
                // Only the dirty bit is touched, so a concurrent tag value never matters.
                if (hit && lat_we_q && !rd_dirty) begin
                    ts_en                = 1'b1;
                    ts_we                = 1'b1;
                    ts_addr              = lat_index_q;
                    ts_wdata[DIRTY_BIT]  = 1'b1;
                    ts_bit_en[DIRTY_BIT] = 1'b1;
                end
            end
            ST_FLUSH: begin
                ts_en     = 1'b1;
                ts_we     = 1'b1;
                ts_addr   = flush_cnt_q;
                ts_bit_en = '1;
                if (flush_cnt_q == LAST_IDX) begin
                    flush_cnt_nxt  = '0;
                    flush_done_nxt = 1'b1;
                    state_nxt      = ST_IDLE;
                end else begin
                    flush_cnt_nxt = flush_cnt_q + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            flush_cnt_q  <= '0;
            flush_done_q <= 1'b0;
            lat_index_q  <= '0;
            lat_tag_q    <= '0;
            lat_we_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_dirty_q  <= 1'b0;
            rsp_victim_q <= '0;
        end else begin
            state_q      <= state_nxt;
            flush_cnt_q  <= flush_cnt_nxt;
            flush_done_q <= flush_done_nxt;
            rsp_valid_q  <= lookup_done;
            if (accept_req) begin
                lat_index_q <= bus.req_index_i;
                lat_tag_q   <= bus.req_tag_i;
                lat_we_q    <= bus.req_we_i;
            end
            if (lookup_done) begin
                rsp_hit_q    <= hit;
                rsp_dirty_q  <= rd_dirty;
                rsp_victim_q <= rd_tag;
            end
        end
    end

    assign bus.refill_ready_o   = (state_q == ST_IDLE) && !bus.flush_i;
    assign bus.req_ready_o      = (state_q == ST_IDLE) && !bus.flush_i && !bus.refill_valid_i;
    assign bus.flush_done_o     = flush_done_q;
    assign bus.rsp_valid_o      = rsp_valid_q;
    assign bus.rsp_hit_o        = rsp_hit_q;
    assign bus.rsp_dirty_o      = rsp_dirty_q;
    assign bus.rsp_victim_tag_o = rsp_victim_q;
    assign bus.ts_en_o          = ts_en;
    assign bus.ts_we_o          = ts_we;
    assign bus.ts_addr_o        = ts_addr;
    assign bus.ts_wdata_o       = ts_wdata;
    assign bus.ts_bit_en_o      = ts_bit_en;
endmodule
